sram_nr1w_clr: RTL and testbench
================================

// Module: sram_nr1w_clr
// PURPOSE
// - Parametrised N-read/1-write working memory for the Bellman-Ford datapath, generalising SRAM_1R1W/SRAM_2R1W.
// - Adds per-lane write mask, selectable read-during-write bypass and a hardware clear engine that fills every
//   entry with the "infinity" distance after reset, so no $readmemh preload of working memory is needed.
// - Sits between bellmanford and its working/output memory ports; one instance replaces each fixed-port SRAM.
// PARAMETERS
// - DATA_W    128     word width in bits; must be a multiple of LANE_W
// - ADDR_W    13      address width
// - DEPTH     8192    number of words; DEPTH <= 2**ADDR_W
// - NUM_RD    2       number of combinational read ports (1..4)
// - LANE_W    16      write-mask granularity (one distance field)
// - INIT_LANE 16'h7FFF value written to every lane by the clear engine
// - BYPASS    1       1: read of the address being written returns the merged new word; 0: returns the old word
// - CLR_EN    1       1: clear engine runs after reset; 0: Ready rises immediately after reset
// PORTS
// - clock        in   1                  system clock, all state updates on rising edge
// - reset        in   1                  synchronous, active-low reset
// - WE           in   1                  write enable
// - WriteAddress in   ADDR_W             write address
// - WriteBus     in   DATA_W             write data
// - WriteMask    in   DATA_W/LANE_W      1 = lane i written, 0 = lane i kept
// - ReadAddress  in   NUM_RD*ADDR_W      port k address at [k*ADDR_W +: ADDR_W]
// - ReadBus      out  NUM_RD*DATA_W      port k data at [k*DATA_W +: DATA_W]
// - Ready        out  1                  clear complete, user writes accepted
// - DropErr      out  1                  sticky: a user write arrived while Ready=0
// BEHAVIOUR
// - Reset (reset=0 at edge): Ready<=0, DropErr<=0, clear pointer<=0, FSM<=CLEAR (CLR_EN=1) or READY (CLR_EN=0).
//   Array contents are not modified by reset itself. Reset mid-clear restarts the clear from address 0.
// - FSM: CLEAR -> write {DATA_W/LANE_W{INIT_LANE}} to pointer each cycle, pointer++; at pointer==DEPTH-1 write,
//   go READY next edge. READY is terminal until reset. Clear takes exactly DEPTH cycles; Ready=1 from cycle DEPTH+1.
// - CLR_EN=0: Ready=1 on the first edge with reset=1; contents unchanged.
// - Writes: when Ready=1 and WE=1, lanes with WriteMask[i]=1 take WriteBus lane i at the rising edge; others hold.
//   WriteMask all-zero with WE=1 is a legal no-op. WriteAddress >= DEPTH: write ignored, no flag.
// - WE=1 while Ready=0 (incl. reset cycles excluded): write dropped, DropErr<=1, held until reset.
// - Reads: combinational, zero latency, all NUM_RD ports independent; same address on several ports legal.
//   While Ready=0 every ReadBus returns {INIT_LANE} pattern regardless of address.
//   ReadAddress >= DEPTH returns all-zero.
// - Read-during-write (Ready=1, WE=1, ReadAddress==WriteAddress): BYPASS=1 -> merged word (masked lanes new,
//   others old); BYPASS=0 -> old word; new value visible next cycle either way.
// - Ready and DropErr are registered outputs; ReadBus is combinational from array, addresses and write inputs.
// STRUCTURE
// - Package sram_pkg: INF_DIST (16'h7FFF), lane-merge function merge_lanes(old,new,mask), FSM state enum
//   {S_CLEAR, S_READY}.
// - Sub-module sram_clr_fsm: state register, clear pointer counter, Ready/DropErr flags, clear write strobe.
// - Top: array reg [DATA_W-1:0] mem[0:DEPTH-1], write mux (clear vs user), generate loop over NUM_RD read ports.
// TESTING
// - DEPTH=16, CLR_EN=1: release reset at cycle 0 -> Ready=0 for 16 cycles, Ready=1 at cycle 17; every read = 0x7FFF lanes.
// - Ready=1, WE=1, addr 5, data lane0=0x0003, mask 8'h01 -> next cycle addr 5 = 0x7FFF..7FFF_0003; other lanes unchanged.
// - BYPASS=1, WE to addr 3 with 0x1234 all lanes, ReadAddress port1=3 same cycle -> ReadBus1=0x1234 pattern;
//   rerun BYPASS=0 -> 0x7FFF pattern that cycle, 0x1234 next.
// - WE=1 at cycle 4 of clear -> DropErr=1 next edge, stays 1; target word still 0x7FFF after clear.
// - Reset pulled low at clear cycle 8 after prior writes to addr 12 -> clear restarts at 0, addr 12 = 0x7FFF at Ready.
// - NUM_RD=4, all ports reading addrs 0,1,1,20 (DEPTH=16) -> ports 0-2 return stored words, port 3 returns 0.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the N-read/1-write working memory: the "infinity"
// distance, the clear-engine state encoding and the lane-merge helper.
package sram_pkg;

    localparam logic [15:0] INF_DIST = 16'h7FFF;

    // Fixed container width for the merge helper; callers zero-extend into it
    // and take back their own DATA_W slice.
    localparam int MRG_W     = 512;
    localparam int MRG_LANES = 64;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } clr_state_e;

    // Lane i of the result comes from new_word when mask[i] is set, otherwise from old_word.
    function automatic logic [MRG_W-1:0] merge_lanes(
        input logic [MRG_W-1:0]     old_word,
        input logic [MRG_W-1:0]     new_word,
        input logic [MRG_LANES-1:0] mask,
        input int                   lane_w
    );
        logic [MRG_W-1:0] res;
        logic [5:0]       lane_idx;
        res = old_word;
        for (int i = 0; i < MRG_W; i++) begin
            lane_idx = 6'(i / lane_w);
            if (mask[lane_idx]) begin
                res[i] = new_word[i];
            end else begin
                res[i] = old_word[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_clr_fsm.sv
// Clear engine for sram_nr1w_clr: walks the clear pointer over every entry
// after reset, then raises Ready. Also latches the sticky dropped-write flag.
module sram_clr_fsm
    import sram_pkg::*;
#(
    parameter int DEPTH  = 8192,
    parameter int IDX_W  = 13,
    parameter int CLR_EN = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    output logic             ready,
    output logic             drop_err,
    output logic             clr_we,
    output logic [IDX_W-1:0] clr_addr
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    clr_state_e       state_r;
    clr_state_e       next_s;
    logic [IDX_W-1:0] ptr_r;
    logic             ready_r;
    logic             drop_r;
    logic             clr_we_s;

    // State register: reset selects whether a clear pass runs at all.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= (CLR_EN != 0) ? S_CLEAR : S_READY;
        end else begin
            state_r <= next_s;
        end
    end

    // Next state: leave CLEAR once the last entry is being written; READY is terminal.
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_CLEAR: begin
                if (ptr_r == LAST_IDX) begin
                    next_s = S_READY;
                end else begin
                    next_s = S_CLEAR;
                end
            end
            S_READY: next_s = S_READY;
            default: next_s = S_CLEAR;
        endcase
    end

    // Outputs: one clear write per cycle while clearing and out of reset.
    always_comb begin
        clr_we_s = 1'b0;
        case (state_r)
            S_CLEAR: clr_we_s = reset;
            S_READY: clr_we_s = 1'b0;
            default: clr_we_s = 1'b0;
        endcase
    end

    // Clear pointer: restarts at entry 0 on every reset, advances with each clear write.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr_r <= '0;
        end else if (clr_we_s) begin
            ptr_r <= ptr_r + 1'b1;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Status flags: Ready follows the state one cycle later; DropErr is sticky until reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ready_r <= 1'b0;
            drop_r  <= 1'b0;
        end else begin
            ready_r <= (state_r == S_READY);
            if (we && !ready_r) begin
                drop_r <= 1'b1;
            end else begin
                drop_r <= drop_r;
            end
        end
    end

    assign ready    = ready_r;
    assign drop_err = drop_r;
    assign clr_we   = clr_we_s;
    assign clr_addr = ptr_r;

endmodule

// File: rtl/sram_nr1w_clr.sv
// N-read/1-write working memory for the Bellman-Ford datapath with per-lane
// write mask, optional read-during-write bypass and a post-reset clear engine
// that fills every entry with the infinity distance.
module sram_nr1w_clr
    import sram_pkg::*;
#(
    parameter int                DATA_W    = 128,
    parameter int                ADDR_W    = 13,
    parameter int                DEPTH     = 8192,
    parameter int                NUM_RD    = 2,
    parameter int                LANE_W    = 16,
    parameter logic [LANE_W-1:0] INIT_LANE = LANE_W'(INF_DIST),
    parameter int                BYPASS    = 1,
    parameter int                CLR_EN    = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     WE,
    input  logic [ADDR_W-1:0]        WriteAddress,
    input  logic [DATA_W-1:0]        WriteBus,
    input  logic [DATA_W/LANE_W-1:0] WriteMask,
    input  logic [NUM_RD*ADDR_W-1:0] ReadAddress,
    output logic [NUM_RD*DATA_W-1:0] ReadBus,
    output logic                     Ready,
    output logic                     DropErr
);

    localparam int                NLANES    = DATA_W / LANE_W;
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_A   = (ADDR_W + 1)'(DEPTH);
    localparam logic [DATA_W-1:0] INIT_WORD = {NLANES{INIT_LANE}};

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              clr_we_s;
    logic [IDX_W-1:0]  clr_addr_s;
    logic              wr_in_range_s;
    logic              user_we_s;
    logic [IDX_W-1:0]  widx_s;
    logic [DATA_W-1:0] old_word_s;
    logic [DATA_W-1:0] merged_s;
    logic [MRG_W-1:0]  merged_ext_s;
    logic              unused_merge_hi_s;

    sram_clr_fsm #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .CLR_EN(CLR_EN)
    ) u_clr_fsm (
        .clock   (clock),
        .reset   (reset),
        .we      (WE),
        .ready   (Ready),
        .drop_err(DropErr),
        .clr_we  (clr_we_s),
        .clr_addr(clr_addr_s)
    );

    // Write decode: accept only in-range user writes once Ready, and build the merged word.
    always_comb begin
        wr_in_range_s = ({1'b0, WriteAddress} < DEPTH_A);
        widx_s        = WriteAddress[IDX_W-1:0];
        user_we_s     = Ready && WE && reset && wr_in_range_s;
        old_word_s    = mem[widx_s];
        merged_ext_s  = merge_lanes(MRG_W'(old_word_s), MRG_W'(WriteBus),
                                    MRG_LANES'(WriteMask), LANE_W);
        merged_s      = merged_ext_s[DATA_W-1:0];
    end

    assign unused_merge_hi_s = ^merged_ext_s[MRG_W-1:DATA_W];

    // Array update: the clear engine owns the write port until Ready; reset never touches contents.
    always_ff @(posedge clock) begin
        if (clr_we_s) begin
            mem[clr_addr_s] <= INIT_WORD;
        end else if (user_we_s) begin
            mem[widx_s] <= merged_s;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] raddr_s;
        logic [IDX_W-1:0]  ridx_s;
        logic [DATA_W-1:0] rword_s;

        assign raddr_s = ReadAddress[k*ADDR_W +: ADDR_W];
        assign ridx_s  = raddr_s[IDX_W-1:0];

        // Read mux: clear pattern before Ready, zero out of range, optional bypass, else array.
        always_comb begin
            rword_s = '0;
            if (!Ready) begin
                rword_s = INIT_WORD;
            end else if ({1'b0, raddr_s} >= DEPTH_A) begin
                rword_s = '0;
            end else if ((BYPASS != 0) && user_we_s && (raddr_s == WriteAddress)) begin
                rword_s = merged_s;
            end else begin
                rword_s = mem[ridx_s];
            end
        end

        assign ReadBus[k*DATA_W +: DATA_W] = rword_s;
    end

endmodule

// File: tb/tb_sram_nr1w_clr.sv
// Bench for sram_nr1w_clr: directed scenarios plus random traffic, checked
// against a behavioural memory model. Two clear-enabled instances differ only
// in BYPASS; a third has the clear engine disabled.
module tb_sram_nr1w_clr;

    localparam int DW = 128;
    localparam int AW = 5;
    localparam int DP = 16;
    localparam int NR = 4;
    localparam int LW = 16;
    localparam int NL = DW / LW;
    localparam logic [DW-1:0] INIT = {NL{16'h7FFF}};

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic             rst;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [DW-1:0]    wdata;
    logic [NL-1:0]    wmask;
    logic [AW-1:0]    raddr [NR];
    logic [NR*AW-1:0] ra_bus;
    logic [NR*DW-1:0] rbus_b, rbus_n, rbus_c;
    logic             rdy_b, rdy_n, rdy_c, drp_b, drp_n, drp_c;

    always_comb begin
        ra_bus = '0;
        for (int k = 0; k < NR; k++) ra_bus[k*AW +: AW] = raddr[k];
    end

    sram_nr1w_clr #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .NUM_RD(NR), .LANE_W(LW),
                    .BYPASS(1), .CLR_EN(1)) dut_b (
        .clock(clock), .reset(rst), .WE(we), .WriteAddress(waddr), .WriteBus(wdata),
        .WriteMask(wmask), .ReadAddress(ra_bus), .ReadBus(rbus_b), .Ready(rdy_b), .DropErr(drp_b));

    sram_nr1w_clr #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .NUM_RD(NR), .LANE_W(LW),
                    .BYPASS(0), .CLR_EN(1)) dut_n (
        .clock(clock), .reset(rst), .WE(we), .WriteAddress(waddr), .WriteBus(wdata),
        .WriteMask(wmask), .ReadAddress(ra_bus), .ReadBus(rbus_n), .Ready(rdy_n), .DropErr(drp_n));

    sram_nr1w_clr #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .NUM_RD(NR), .LANE_W(LW),
                    .BYPASS(1), .CLR_EN(0)) dut_c (
        .clock(clock), .reset(rst), .WE(we), .WriteAddress(waddr), .WriteBus(wdata),
        .WriteMask(wmask), .ReadAddress(ra_bus), .ReadBus(rbus_c), .Ready(rdy_c), .DropErr(drp_c));

    // Reference model state
    logic [DW-1:0] mdl [DP];
    int            cnt;        // edges with reset released since the last reset
    bit            m_ready, m_drop, c_ready, c_drop;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge_m(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                              input logic [NL-1:0] m);
        logic [DW-1:0] r;
        for (int l = 0; l < NL; l++) r[l*LW +: LW] = m[l] ? n[l*LW +: LW] : o[l*LW +: LW];
        return r;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (!m_ready) return INIT;
        if (int'(a) >= DP) return '0;
        if (byp && rst && we && a == waddr) return merge_m(mdl[a], wdata, wmask);
        return mdl[a];
    endfunction

    // One clock: check reads before the edge, advance model at the edge, check flags after.
    task automatic cycle();
        #1;
        for (int k = 0; k < NR; k++) begin
            chk($sformatf("rd_byp1_p%0d", k), rbus_b[k*DW +: DW], exp_rd(raddr[k], 1'b1));
            chk($sformatf("rd_byp0_p%0d", k), rbus_n[k*DW +: DW], exp_rd(raddr[k], 1'b0));
            if (!c_ready) chk($sformatf("rd_noclr_p%0d", k), rbus_c[k*DW +: DW], INIT);
            else if (int'(raddr[k]) >= DP) chk($sformatf("rd_noclr_oor_p%0d", k), rbus_c[k*DW +: DW], '0);
        end
        @(posedge clock);
        if (!rst) begin
            cnt = 0; m_ready = 0; m_drop = 0; c_ready = 0; c_drop = 0;
        end else begin
            if (we) begin
                if (m_ready) begin
                    if (int'(waddr) < DP) mdl[waddr] = merge_m(mdl[waddr], wdata, wmask);
                end else begin
                    m_drop = 1;
                end
                if (!c_ready) c_drop = 1;
            end
            cnt++;
            if (cnt == DP) for (int a = 0; a < DP; a++) mdl[a] = INIT;
            m_ready = (cnt >= DP + 1);
            c_ready = (cnt >= 1);
        end
        @(negedge clock);
        chk("ready_byp1", DW'(rdy_b), DW'(m_ready));
        chk("ready_byp0", DW'(rdy_n), DW'(m_ready));
        chk("ready_noclr", DW'(rdy_c), DW'(c_ready));
        chk("drop_byp1", DW'(drp_b), DW'(m_drop));
        chk("drop_byp0", DW'(drp_n), DW'(m_drop));
        chk("drop_noclr", DW'(drp_c), DW'(c_drop));
    endtask

    initial begin
        for (int a = 0; a < DP; a++) mdl[a] = '0;
        cnt = 0; m_ready = 0; m_drop = 0; c_ready = 0; c_drop = 0;
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wmask = '0;
        for (int k = 0; k < NR; k++) raddr[k] = '0;

        repeat (2) cycle();
        chk("reset_ready", DW'(rdy_b), '0);
        chk("reset_drop", DW'(drp_b), '0);

        // Clear pass with a dropped write at clear cycle 4
        rst = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            we = (c == 4); waddr = AW'(7); wdata = {NL{16'hAAAA}}; wmask = '1;
            for (int k = 0; k < NR; k++) raddr[k] = AW'($urandom_range(0, 23));
            cycle();
            if (c <= 16) chk("clear_ready_low", DW'(rdy_b), '0);
            else chk("ready_at_17", DW'(rdy_b), DW'(1));
            if (c == 4) chk("drop_at_4", DW'(drp_b), DW'(1));
        end
        we = 1'b0; raddr[0] = AW'(7);
        cycle();
        chk("drop_target_init", rbus_b[0 +: DW], INIT);
        chk("drop_sticky", DW'(drp_b), DW'(1));

        // Single-lane masked write
        we = 1'b1; waddr = AW'(5); wdata = DW'(16'h0003); wmask = NL'(8'h01); raddr[0] = AW'(5);
        cycle();
        we = 1'b0; #1;
        chk("mask_lane0", rbus_b[0 +: DW], {{7{16'h7FFF}}, 16'h0003});

        // Read-during-write on port 1
        we = 1'b1; waddr = AW'(3); wdata = {NL{16'h1234}}; wmask = '1; raddr[1] = AW'(3);
        #1;
        chk("rdw_byp1_same", rbus_b[DW +: DW], {NL{16'h1234}});
        chk("rdw_byp0_same", rbus_n[DW +: DW], INIT);
        cycle();
        we = 1'b0; #1;
        chk("rdw_byp1_next", rbus_b[DW +: DW], {NL{16'h1234}});
        chk("rdw_byp0_next", rbus_n[DW +: DW], {NL{16'h1234}});

        // Four ports, shared address and out-of-range address
        raddr[0] = AW'(0); raddr[1] = AW'(1); raddr[2] = AW'(1); raddr[3] = AW'(20);
        #1;
        chk("p1_addr1", rbus_b[DW +: DW], INIT);
        chk("p2_addr1", rbus_b[2*DW +: DW], INIT);
        chk("p3_oor", rbus_b[3*DW +: DW], '0);
        cycle();

        // Random traffic
        repeat (300) begin
            we    = 1'($urandom_range(0, 1));
            waddr = AW'($urandom_range(0, 23));
            wdata = {$urandom, $urandom, $urandom, $urandom};
            wmask = NL'($urandom);
            for (int k = 0; k < NR; k++)
                raddr[k] = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, 23));
            cycle();
        end

        // Reset in the middle of a clear pass
        we = 1'b1; waddr = AW'(12); wdata = {NL{16'h5555}}; wmask = '1; raddr[0] = AW'(12);
        cycle();
        we = 1'b0; #1;
        chk("addr12_written", rbus_b[0 +: DW], {NL{16'h5555}});
        rst = 1'b0; cycle();
        rst = 1'b1; repeat (8) cycle();
        rst = 1'b0; cycle();
        chk("midclear_drop_cleared", DW'(drp_b), '0);
        rst = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            cycle();
            if (c == 16) chk("restart_not_ready", DW'(rdy_b), '0);
        end
        chk("restart_ready", DW'(rdy_b), DW'(1));
        #1;
        chk("addr12_cleared", rbus_b[0 +: DW], INIT);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
